iir_cascade_tdm: RTL and testbench

IIR_CASCADE_TDM -- requirements
Module: iir_cascade_tdm

---
 rtl/iir_cascade_tdm_pkg.sv | 43 ++++
 rtl/iir_cascade_tdm_if.sv | 27 ++
 rtl/iir_cascade_tdm_mac.sv | 51 +++++
 rtl/iir_cascade_tdm.sv | 216 +++++++++++++++++++++
 tb/tb_iir_cascade_tdm.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iir_cascade_tdm_pkg.sv
// Shared definitions for the time-multiplexed biquad cascade: FSM states,
// coefficient slot order, Q2 fixed-point constants and the saturation helper.
`timescale 1ns/1ps
package iir_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      WB   = 2'd2,
      OUT  = 2'd3
   } state_t;

   localparam int NCOEF = 5;

   localparam logic [2:0] B0 = 3'd0;
   localparam logic [2:0] B1 = 3'd1;
   localparam logic [2:0] B2 = 3'd2;
   localparam logic [2:0] A1 = 3'd3;
   localparam logic [2:0] A2 = 3'd4;

   localparam int Q_INT_BITS = 2;
   localparam int SAT_W      = 64;

   // Half an LSB of the result, so the arithmetic shift rounds to nearest.
   function automatic logic signed [SAT_W-1:0] round_const(input int cw);
      return 64'sd1 <<< (cw - Q_INT_BITS - 1);
   endfunction

   function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                       input int w);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) begin
         return hi;
      end else if (v < lo) begin
         return lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/iir_cascade_tdm_if.sv
// Sample stream bundle: input handshake towards the filter and output
// handshake back from it.
`timescale 1ns/1ps
interface iir_cascade_tdm_if #(
   parameter int DW  = 24,
   parameter int CHW = 1
);
   logic signed [DW-1:0]  in_data;
   logic [CHW-1:0]        in_ch;
   logic                  in_valid;
   logic                  in_ready;
   logic signed [DW-1:0]  out_data;
   logic [CHW-1:0]        out_ch;
   logic                  out_sat;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output in_data, in_ch, in_valid, out_ready,
      input  in_ready, out_data, out_ch, out_sat, out_valid
   );

   modport slave (
      input  in_data, in_ch, in_valid, out_ready,
      output in_ready, out_data, out_ch, out_sat, out_valid
   );
endinterface

// File: rtl/iir_cascade_tdm_mac.sv
// Shared multiply-accumulate unit: one signed product per enabled cycle,
// then round-to-nearest from Q2 scaling and clamp to the sample width.
`timescale 1ns/1ps
module iir_mac
   import iir_pkg::*;
#(
   parameter int DW = 24,
   parameter int CW = 24
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 first,
   input  logic                 sub,
   input  logic signed [CW-1:0] coef,
   input  logic signed [DW-1:0] sample,
   output logic signed [DW-1:0] result,
   output logic                 sat
);

   localparam int PW   = DW + CW;
   localparam int ACCW = DW + CW + 4;

   logic signed [PW-1:0]    prod;
   logic signed [ACCW-1:0]  prod_ext;
   logic signed [ACCW-1:0]  base;
   logic signed [ACCW-1:0]  acc_q;
   logic signed [SAT_W-1:0] acc_wide;
   logic signed [SAT_W-1:0] rounded;
   logic signed [SAT_W-1:0] clipped;

   assign prod     = PW'(coef) * PW'(sample);
   assign prod_ext = ACCW'(prod);
   assign base     = first ? '0 : acc_q;

   // Feedback taps arrive with sub set so the stored a1/a2 keep their textbook sign.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else if (en) begin
         acc_q <= sub ? (base - prod_ext) : (base + prod_ext);
      end
   end

   assign acc_wide = SAT_W'(acc_q);
   assign rounded  = (acc_wide + round_const(CW)) >>> (CW - Q_INT_BITS);
   assign clipped  = saturate(rounded, DW);
   assign result   = clipped[DW-1:0];
   assign sat      = (clipped != rounded);

endmodule

// File: rtl/iir_cascade_tdm.sv
// Cascade of NSEC Direct Form I biquads shared over NCH channels, evaluated
// one tap per cycle on a single MAC; holds the FSM, filter state and coefficients.
`timescale 1ns/1ps
module iir_cascade_tdm
   import iir_pkg::*;
#(
   parameter  int DW   = 24,
   parameter  int CW   = 24,
   parameter  int NSEC = 4,
   parameter  int NCH  = 2,
   localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int AW   = $clog2(5 * NSEC)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   iir_cascade_tdm_if.slave     s,
   input  logic                 coef_we,
   input  logic [AW-1:0]        coef_addr,
   input  logic [CW-1:0]        coef_wdata,
   input  logic                 clear,
   output logic                 busy,
   output logic                 coef_err
);

   localparam int SW = (NSEC > 1) ? $clog2(NSEC) : 1;
   localparam int NC = NCOEF * NSEC;
   localparam logic [CW-1:0] COEF_ONE = {2'b01, {(CW-2){1'b0}}};

   state_t               state_q, state_d;
   logic [2:0]           k_q, k_d;
   logic [SW-1:0]        sec_q, sec_d;
   logic [CHW-1:0]       ch_q;
   logic [CHW-1:0]       in_ch_eff;
   logic signed [DW-1:0] sec_in_q;
   logic                 sat_acc_q;
   logic                 accept;
   logic                 last_sec;

   logic signed [DW-1:0] x1_q [NCH][NSEC];
   logic signed [DW-1:0] x2_q [NCH][NSEC];
   logic signed [DW-1:0] y1_q [NCH][NSEC];
   logic signed [DW-1:0] y2_q [NCH][NSEC];
   logic signed [CW-1:0] coef_q [NC];

   logic [AW-1:0]        cidx;
   logic signed [CW-1:0] mac_coef;
   logic signed [DW-1:0] mac_sample;
   logic                 mac_sub;
   logic                 mac_en;
   logic                 mac_first;
   logic signed [DW-1:0] mac_result;
   logic                 mac_sat;

   assign s.in_ready  = rst_n && (state_q == IDLE) && !clear;
   assign s.out_valid = (state_q == OUT);
   assign busy        = (state_q != IDLE);
   assign accept      = s.in_valid && s.in_ready;
   assign last_sec    = (sec_q == SW'(NSEC - 1));
   assign in_ch_eff   = (32'(s.in_ch) >= 32'(NCH)) ? CHW'(NCH - 1) : s.in_ch;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         sec_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         sec_q   <= sec_d;
      end
   end

   // Each section costs five MAC cycles plus one write-back; clear overrides everything.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      sec_d   = sec_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = MAC;
               k_d     = B0;
               sec_d   = '0;
            end
         end
         MAC: begin
            if (k_q == A2) begin
               state_d = WB;
            end else begin
               k_d = k_q + 3'd1;
            end
         end
         WB: begin
            if (last_sec) begin
               state_d = OUT;
            end else begin
               state_d = MAC;
               k_d     = B0;
               sec_d   = sec_q + SW'(1);
            end
         end
         OUT: begin
            if (s.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (clear) begin
         state_d = IDLE;
      end
   end

   assign cidx     = AW'(NCOEF * int'(sec_q) + int'(k_q));
   assign mac_coef = coef_q[cidx];
   assign mac_en   = (state_q == MAC);
   assign mac_first = (k_q == B0);

   always_comb begin
      mac_sample = sec_in_q;
      mac_sub    = 1'b0;
      case (k_q)
         B1: mac_sample = x1_q[ch_q][sec_q];
         B2: mac_sample = x2_q[ch_q][sec_q];
         A1: begin
            mac_sample = y1_q[ch_q][sec_q];
            mac_sub    = 1'b1;
         end
         A2: begin
            mac_sample = y2_q[ch_q][sec_q];
            mac_sub    = 1'b1;
         end
         default: ;
      endcase
   end

   iir_mac #(
      .DW (DW),
      .CW (CW)
   ) u_mac (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (mac_en),
      .first  (mac_first),
      .sub    (mac_sub),
      .coef   (mac_coef),
      .sample (mac_sample),
      .result (mac_result),
      .sat    (mac_sat)
   );

   // History only moves in write-back, so an abort leaves no half-updated section.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ch_q       <= '0;
         sec_in_q   <= '0;
         sat_acc_q  <= 1'b0;
         s.out_data <= '0;
         s.out_ch   <= '0;
         s.out_sat  <= 1'b0;
         for (int c = 0; c < NCH; c++) begin
            for (int j = 0; j < NSEC; j++) begin
               x1_q[c][j] <= '0;
               x2_q[c][j] <= '0;
               y1_q[c][j] <= '0;
               y2_q[c][j] <= '0;
            end
         end
      end else if (clear) begin
         for (int c = 0; c < NCH; c++) begin
            for (int j = 0; j < NSEC; j++) begin
               x1_q[c][j] <= '0;
               x2_q[c][j] <= '0;
               y1_q[c][j] <= '0;
               y2_q[c][j] <= '0;
            end
         end
      end else begin
         if (accept) begin
            ch_q      <= in_ch_eff;
            sec_in_q  <= s.in_data;
            sat_acc_q <= 1'b0;
         end
         if (state_q == WB) begin
            x2_q[ch_q][sec_q] <= x1_q[ch_q][sec_q];
            x1_q[ch_q][sec_q] <= sec_in_q;
            y2_q[ch_q][sec_q] <= y1_q[ch_q][sec_q];
            y1_q[ch_q][sec_q] <= mac_result;
            sec_in_q          <= mac_result;
            sat_acc_q         <= sat_acc_q | mac_sat;
            if (last_sec) begin
               s.out_data <= mac_result;
               s.out_ch   <= ch_q;
               s.out_sat  <= sat_acc_q | mac_sat;
            end
         end
      end
   end

   // Writes land only while idle; anything else is dropped and remembered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         coef_err <= 1'b0;
         for (int i = 0; i < NC; i++) begin
            coef_q[i] <= (i % NCOEF == 0) ? COEF_ONE : '0;
         end
      end else if (coef_we) begin
         if ((state_q == IDLE) && (32'(coef_addr) < 32'(NC))) begin
            coef_q[coef_addr] <= coef_wdata;
         end else begin
            coef_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_iir_cascade_tdm.sv
// Scoreboard bench for iir_cascade_tdm: an integer biquad model predicts each
// output when a sample is accepted; outputs are popped and compared on arrival.
`timescale 1ns/1ps
module tb_iir_cascade_tdm;

   localparam int DW   = 24;
   localparam int CW   = 24;
   localparam int NSEC = 4;
   localparam int NCH  = 2;
   localparam int CHW  = 1;
   localparam int AW   = 5;
   localparam longint MAXV = 64'sd8388607;
   localparam longint MINV = -64'sd8388608;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          coef_we = 1'b0;
   logic [AW-1:0] coef_addr = '0;
   logic [CW-1:0] coef_wdata = '0;
   logic          clear = 1'b0;
   logic          busy;
   logic          coef_err;

   iir_cascade_tdm_if #(.DW(DW), .CHW(CHW)) io();

   iir_cascade_tdm #(
      .DW   (DW),
      .CW   (CW),
      .NSEC (NSEC),
      .NCH  (NCH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s          (io),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_wdata (coef_wdata),
      .clear      (clear),
      .busy       (busy),
      .coef_err   (coef_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint data;
      int     ch;
      bit     sat;
   } exp_t;

   exp_t   sbq[$];
   int     errors = 0;
   int     checks = 0;
   longint mc  [5*NSEC];
   longint mx1 [NCH][NSEC];
   longint mx2 [NCH][NSEC];
   longint my1 [NCH][NSEC];
   longint my2 [NCH][NSEC];

   task automatic checkOutput(input string tag, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, actual, actual, expected, expected);
      end
   endtask

   function automatic longint sx24(input logic [DW-1:0] v);
      return longint'($signed(v));
   endfunction

   function automatic void modelClear();
      for (int c = 0; c < NCH; c++) begin
         for (int j = 0; j < NSEC; j++) begin
            mx1[c][j] = 0;
            mx2[c][j] = 0;
            my1[c][j] = 0;
            my2[c][j] = 0;
         end
      end
   endfunction

   function automatic void modelReset();
      for (int i = 0; i < 5*NSEC; i++) begin
         mc[i] = (i % 5 == 0) ? 64'sd4194304 : 64'sd0;
      end
      modelClear();
   endfunction

   function automatic exp_t modelStep(input longint x, input int ch);
      exp_t   e;
      longint v;
      longint acc;
      longint r;
      int     c;
      c     = (ch >= NCH) ? NCH - 1 : ch;
      e.ch  = c;
      e.sat = 1'b0;
      v     = x;
      for (int j = 0; j < NSEC; j++) begin
         acc = mc[5*j] * v + mc[5*j+1] * mx1[c][j] + mc[5*j+2] * mx2[c][j]
             - mc[5*j+3] * my1[c][j] - mc[5*j+4] * my2[c][j];
         r = (acc + 64'sd2097152) >>> 22;
         if (r > MAXV) begin
            r = MAXV;
            e.sat = 1'b1;
         end else if (r < MINV) begin
            r = MINV;
            e.sat = 1'b1;
         end
         mx2[c][j] = mx1[c][j];
         mx1[c][j] = v;
         my2[c][j] = my1[c][j];
         my1[c][j] = r;
         v = r;
      end
      e.data = v;
      return e;
   endfunction

   task automatic applyStimulus(input logic [DW-1:0] d, input int ch, input bit expect_out);
      int   n;
      exp_t e;
      n = 0;
      io.in_data  = d;
      io.in_ch    = ch[CHW-1:0];
      io.in_valid = 1'b1;
      while (!io.in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!io.in_ready) begin
         checkOutput("accept_timeout", 0, 1);
         io.in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      io.in_valid = 1'b0;
      e = modelStep(sx24(d), ch);
      if (expect_out) sbq.push_back(e);
   endtask

   task automatic collectOutput(output int lat, output longint expdata);
      int   n;
      exp_t e;
      n = 0;
      expdata = 0;
      while (!io.out_valid && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      lat = n + 1;
      if (!io.out_valid) begin
         checkOutput("out_timeout", 0, 1);
         return;
      end
      if (sbq.size() == 0) begin
         checkOutput("unexpected_out", 1, 0);
      end else begin
         e = sbq.pop_front();
         expdata = e.data;
         checkOutput("out_data", sx24(io.out_data), e.data);
         checkOutput("out_ch", longint'(io.out_ch), longint'(e.ch));
         checkOutput("out_sat", longint'(io.out_sat), longint'(e.sat));
      end
      if (io.out_ready) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic writeCoef(input int addr, input logic [CW-1:0] v, input bit apply);
      coef_we    = 1'b1;
      coef_addr  = addr[AW-1:0];
      coef_wdata = v;
      @(posedge clk); #1;
      coef_we = 1'b0;
      if (apply) mc[addr] = sx24(v);
   endtask

   task automatic pulseClear();
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      modelClear();
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_in_ready", longint'(io.in_ready), 0);
      checkOutput("rst_out_valid", longint'(io.out_valid), 0);
      checkOutput("rst_busy", longint'(busy), 0);
      checkOutput("rst_coef_err", longint'(coef_err), 0);
      checkOutput("rst_out_data", sx24(io.out_data), 0);
      checkOutput("rst_out_sat", longint'(io.out_sat), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("post_rst_in_ready", longint'(io.in_ready), 1);
      modelReset();
      sbq.delete();
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int     lat;
      longint ed;
      int     seen;

      io.in_data   = '0;
      io.in_ch     = '0;
      io.in_valid  = 1'b0;
      io.out_ready = 1'b1;

      $display("[TB] reset and impulse through identity cascade");
      doReset();

      applyStimulus(24'h100000, 0, 1'b1);
      collectOutput(lat, ed);
      checkOutput("latency", longint'(lat), 25);
      checkOutput("impulse_peak", sx24(io.out_data), 64'h100000);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(24'h000000, 0, 1'b1);
         collectOutput(lat, ed);
         checkOutput("impulse_tail", sx24(io.out_data), 0);
      end

      $display("[TB] one-pole feedback on ch0, ch1 interleaved");
      writeCoef(3, 24'hE00000, 1'b1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus((i == 0) ? 24'h100000 : 24'h000000, 0, 1'b1);
         collectOutput(lat, ed);
         checkOutput("decay_ch0", sx24(io.out_data), 64'h100000 >>> i);
         applyStimulus(24'h000000, 1, 1'b1);
         collectOutput(lat, ed);
         checkOutput("decay_ch1", sx24(io.out_data), 0);
      end
      writeCoef(3, 24'h000000, 1'b1);
      pulseClear();

      $display("[TB] saturation");
      writeCoef(0, 24'h7FFFFF, 1'b1);
      applyStimulus(24'h600000, 0, 1'b1);
      collectOutput(lat, ed);
      checkOutput("sat_pos", sx24(io.out_data), MAXV);
      checkOutput("sat_pos_flag", longint'(io.out_sat), 1);
      applyStimulus(24'hA00000, 1, 1'b1);
      collectOutput(lat, ed);
      checkOutput("sat_neg", sx24(io.out_data), MINV);
      checkOutput("sat_neg_flag", longint'(io.out_sat), 1);
      writeCoef(0, 24'h400000, 1'b1);

      $display("[TB] output backpressure");
      io.out_ready = 1'b0;
      applyStimulus(24'h123456, 1, 1'b1);
      collectOutput(lat, ed);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checkOutput("stall_valid", longint'(io.out_valid), 1);
         checkOutput("stall_data", sx24(io.out_data), ed);
         checkOutput("stall_in_ready", longint'(io.in_ready), 0);
      end
      io.out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("release_in_ready", longint'(io.in_ready), 1);
      checkOutput("release_valid", longint'(io.out_valid), 0);

      $display("[TB] clear mid-computation");
      applyStimulus(24'h100000, 0, 1'b0);
      repeat (9) begin
         @(posedge clk); #1;
      end
      pulseClear();
      seen = 0;
      repeat (40) begin
         if (io.out_valid) seen = 1;
         @(posedge clk); #1;
      end
      checkOutput("clear_no_out", longint'(seen), 0);
      checkOutput("clear_idle", longint'(busy), 0);
      applyStimulus(24'h100000, 0, 1'b1);
      collectOutput(lat, ed);
      checkOutput("clear_impulse", sx24(io.out_data), 64'h100000);
      applyStimulus(24'h000000, 0, 1'b1);
      collectOutput(lat, ed);
      checkOutput("clear_tail", sx24(io.out_data), 0);

      $display("[TB] dropped coefficient write and reset mid-computation");
      applyStimulus(24'h100000, 1, 1'b1);
      repeat (2) begin
         @(posedge clk); #1;
      end
      writeCoef(0, 24'h200000, 1'b0);
      checkOutput("coef_err_set", longint'(coef_err), 1);
      collectOutput(lat, ed);
      applyStimulus(24'h050000, 0, 1'b1);
      collectOutput(lat, ed);
      checkOutput("coef_err_sticky", longint'(coef_err), 1);

      writeCoef(0, 24'h200000, 1'b1);
      applyStimulus(24'h100000, 0, 1'b1);
      collectOutput(lat, ed);
      checkOutput("half_gain", sx24(io.out_data), 64'h080000);
      applyStimulus(24'h100000, 0, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      doReset();
      seen = 0;
      repeat (30) begin
         if (io.out_valid) seen = 1;
         @(posedge clk); #1;
      end
      checkOutput("reset_no_out", longint'(seen), 0);
      applyStimulus(24'h100000, 0, 1'b1);
      collectOutput(lat, ed);
      checkOutput("identity_restored", sx24(io.out_data), 64'h100000);
      checkOutput("scoreboard_empty", longint'(sbq.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
